// File: rtl/cok_bankali_sram_arabirimi_if.sv
// Core-side word request / read response bundle for the multi-bank SRAM bridge.
// Signal names carry the bridge's point of view (_i into the bridge, _o out of it).
interface cok_bankali_sram_arabirimi_if #(
  parameter int ADRES_BIT = 13
) ();
  logic                 istek_gecerli_i;
  logic                 istek_hazir_o;
  logic [ADRES_BIT-1:0] istek_adres_i;
  logic [31:0]          istek_veri_i;
  logic [3:0]           istek_maske_i;
  logic                 yanit_gecerli_o;
  logic                 yanit_hazir_i;
  logic [31:0]          yanit_veri_o;

  modport master (
    output istek_gecerli_i, istek_adres_i, istek_veri_i, istek_maske_i, yanit_hazir_i,
    input  istek_hazir_o, yanit_gecerli_o, yanit_veri_o
  );

  modport slave (
    input  istek_gecerli_i, istek_adres_i, istek_veri_i, istek_maske_i, yanit_hazir_i,
    output istek_hazir_o, yanit_gecerli_o, yanit_veri_o
  );
endinterface

// File: rtl/cok_bankali_sram_arabirimi.sv
// Bridges a valid/ready word port onto N OpenRAM-style macros with bank interleaving,
// returning read data in order through a credit-guarded response FIFO.
module cok_bankali_sram_arabirimi #(
  parameter int ADRES_BIT      = 13,
  parameter int BANKA_SAYISI   = 2,
  parameter int SRAM_GECIKME   = 1,
  parameter int CIKIS_DERINLIK = 4,
  parameter int SERPISTIR      = 1,
  localparam int BB = $clog2(BANKA_SAYISI),
  localparam int BA = ADRES_BIT - BB,
  localparam int N  = BANKA_SAYISI
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  cok_bankali_sram_arabirimi_if.slave bus,
  output logic [N-1:0]               csb0_o,
  output logic [N-1:0]               web0_o,
  output logic [4*N-1:0]             wmask0_o,
  output logic [BA*N-1:0]            addr0_o,
  output logic [32*N-1:0]            din0_o,
  output logic [N-1:0]               csb1_o,
  output logic [BA*N-1:0]            addr1_o,
  input  logic [32*N-1:0]            dout1_i
);
  localparam int BW = (BB > 0) ? BB : 1;
  localparam int L  = SRAM_GECIKME;
  localparam int D  = CIKIS_DERINLIK;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int KW = $clog2(D + 1);

  logic [BW-1:0]        banka;
  logic [BA-1:0]        banka_adres;
  logic                 yaz, kabul, oku_kabul, push, pop, yanit_var;
  logic [KW-1:0]        kredi_q, kredi_d, doluluk_q, doluluk_d;
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [31:0]          mem_q [D];
  logic [L-1:0]         vld_q, vld_d;
  logic [L-1:0][BW-1:0] bnk_q, bnk_d;
  logic [N-1:0][BA-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [N-1:0][31:0]   din0_q, din0_d;
  logic [N-1:0][3:0]    wmask0_q, wmask0_d;
  logic [31:0]          push_veri;

  generate
    if (BB == 0) begin : g_tek
      assign banka       = '0;
      assign banka_adres = bus.istek_adres_i;
    end else if (SERPISTIR != 0) begin : g_serp
      assign banka       = bus.istek_adres_i[BB-1:0];
      assign banka_adres = bus.istek_adres_i[ADRES_BIT-1:BB];
    end else begin : g_blok
      assign banka       = bus.istek_adres_i[ADRES_BIT-1 -: BB];
      assign banka_adres = bus.istek_adres_i[BA-1:0];
    end
  endgenerate

  function automatic logic [PW-1:0] sonraki(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Writes never consume credit; reads need a reserved FIFO slot.
  assign yaz               = bus.istek_maske_i != 4'b0000;
  assign bus.istek_hazir_o = ~rst_i & (yaz | (kredi_q != '0));
  assign kabul             = bus.istek_gecerli_i & bus.istek_hazir_o;
  assign oku_kabul         = kabul & ~yaz;

  always_comb begin
    csb0_o   = '1;
    web0_o   = '1;
    csb1_o   = '1;
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    wmask0_d = wmask0_q;
    addr1_d  = addr1_q;
    for (int k = 0; k < N; k++) begin
      if (kabul && (int'(banka) == k)) begin
        if (yaz) begin
          csb0_o[k]   = 1'b0;
          web0_o[k]   = 1'b0;
          addr0_d[k]  = banka_adres;
          din0_d[k]   = bus.istek_veri_i;
          wmask0_d[k] = bus.istek_maske_i;
        end else begin
          csb1_o[k]   = 1'b0;
          addr1_d[k]  = banka_adres;
        end
      end
    end
  end

  assign addr0_o  = addr0_d;
  assign din0_o   = din0_d;
  assign wmask0_o = wmask0_d;
  assign addr1_o  = addr1_d;

  // Bank tag travels with each read so the right dout1 lane is captured on exit.
  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = oku_kabul;
    bnk_d    = bnk_q;
    bnk_d[0] = banka;
    for (int i = 1; i < L; i++) bnk_d[i] = bnk_q[i-1];
  end

  assign push      = vld_q[L-1];
  assign push_veri = dout1_i[32*bnk_q[L-1] +: 32];
  assign yanit_var = doluluk_q != '0;
  assign pop       = yanit_var & bus.yanit_hazir_i;

  assign bus.yanit_gecerli_o = yanit_var;
  assign bus.yanit_veri_o    = yanit_var ? mem_q[rd_q] : '0;

  always_comb begin
    wr_d      = push ? sonraki(wr_q) : wr_q;
    rd_d      = pop ? sonraki(rd_q) : rd_q;
    doluluk_d = doluluk_q;
    if (push && !pop)      doluluk_d = doluluk_q + 1'b1;
    else if (pop && !push) doluluk_d = doluluk_q - 1'b1;
    kredi_d = kredi_q;
    if (oku_kabul && !pop)      kredi_d = kredi_q - 1'b1;
    else if (pop && !oku_kabul) kredi_d = kredi_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kredi_q   <= KW'(D);
      doluluk_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      vld_q     <= '0;
      bnk_q     <= '0;
      addr0_q   <= '0;
      din0_q    <= '0;
      wmask0_q  <= '0;
      addr1_q   <= '0;
    end else begin
      kredi_q   <= kredi_d;
      doluluk_q <= doluluk_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      vld_q     <= vld_d;
      bnk_q     <= bnk_d;
      addr0_q   <= addr0_d;
      din0_q    <= din0_d;
      wmask0_q  <= wmask0_d;
      addr1_q   <= addr1_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_q] <= push_veri;
  end
endmodule
